// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with programmable porches, sync polarity and
// pixel clock-enable divider. The optional colour-bar test pattern on vga_rgb
// is built only when VGA_TEST_PATTERN_EN is defined; otherwise vga_rgb is 0.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned H_POL    = 0,
    parameter int unsigned V_POL    = 0,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned HW       = 11,
    parameter int unsigned VW       = 10
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          en,
    output logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          pixel_flag,
    output logic [HW-1:0] x_pos,
    output logic [VW-1:0] y_pos,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    vga_rgb
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned H_START = H_SYNC + H_BACK;
    localparam int unsigned H_END   = H_START + H_ACTIVE;
    localparam int unsigned V_START = V_SYNC + V_BACK;
    localparam int unsigned V_END   = V_START + V_ACTIVE;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [HW-1:0]    H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]    V_LAST  = VW'(V_TOTAL - 1);
    localparam logic             HS_ACT  = (H_POL != 0);
    localparam logic             VS_ACT  = (V_POL != 0);

    // IDLE: counters parked at 0, first pixel enable loads the origin.
    // RUN: counters advance every pixel enable.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div, div_nxt;
    logic [HW-1:0]    hcount, h_nxt;
    logic [VW-1:0]    vcount, v_nxt;
    logic             ce_c;

    logic             hs_d, vs_d, act_d, ls_d, fs_d;
    logic [HW-1:0]    x_d;
    logic [VW-1:0]    y_d;

    // State, divider and raster counter registers
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state  <= ST_IDLE;
            div    <= '0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            state  <= state_nxt;
            div    <= div_nxt;
            hcount <= h_nxt;
            vcount <= v_nxt;
        end
    end

    // Next-state counters and decode of the outputs from the next counter values
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        h_nxt     = hcount;
        v_nxt     = vcount;
        ce_c      = 1'b0;

        if (!en) begin
            state_nxt = ST_IDLE;
            div_nxt   = '0;
            h_nxt     = '0;
            v_nxt     = '0;
        end else begin
            ce_c    = (div == DIV_MAX);
            div_nxt = ce_c ? '0 : div + DIV_W'(1);
            if (ce_c) begin
                case (state)
                    ST_IDLE: begin
                        state_nxt = ST_RUN;
                        h_nxt     = '0;
                        v_nxt     = '0;
                    end
                    ST_RUN: begin
                        if (hcount == H_LAST) begin
                            h_nxt = '0;
                            v_nxt = (vcount == V_LAST) ? '0 : vcount + VW'(1);
                        end else begin
                            h_nxt = hcount + HW'(1);
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end

        hs_d  = (h_nxt < HW'(H_SYNC)) ? HS_ACT : ~HS_ACT;
        vs_d  = (v_nxt < VW'(V_SYNC)) ? VS_ACT : ~VS_ACT;
        act_d = (h_nxt >= HW'(H_START)) && (h_nxt < HW'(H_END)) &&
                (v_nxt >= VW'(V_START)) && (v_nxt < VW'(V_END));
        x_d   = act_d ? h_nxt - HW'(H_START) : '0;
        y_d   = act_d ? v_nxt - VW'(V_START) : '0;
        ls_d  = (h_nxt == '0);
        fs_d  = ls_d && (v_nxt == '0);
    end

    // Registered timing outputs, refreshed once per pixel period
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            pix_ce      <= 1'b0;
            hsync       <= ~HS_ACT;
            vsync       <= ~VS_ACT;
            pixel_flag  <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            pix_ce      <= 1'b0;
            hsync       <= ~HS_ACT;
            vsync       <= ~VS_ACT;
            pixel_flag  <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_ce <= ce_c;
            if (ce_c) begin
                hsync       <= hs_d;
                vsync       <= vs_d;
                pixel_flag  <= act_d;
                x_pos       <= x_d;
                y_pos       <= y_d;
                line_start  <= ls_d;
                frame_start <= fs_d;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_c;
    logic [7:0] rgb_d;

    // First column of bar k: smallest x with x*8/H_ACTIVE >= k
    function automatic logic [HW-1:0] bar_thresh(input int unsigned k);
        return HW'((k * H_ACTIVE + 7) / 8);
    endfunction

    // Colour-bar index and RGB332 colour for the next pixel
    always_comb begin
        bar_c = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (x_d >= bar_thresh(k)) begin
                bar_c = bar_c + 3'd1;
            end
        end
        case (bar_c)
            3'd0:    rgb_d = 8'hFF;
            3'd1:    rgb_d = 8'hFC;
            3'd2:    rgb_d = 8'h1F;
            3'd3:    rgb_d = 8'h1C;
            3'd4:    rgb_d = 8'hE3;
            3'd5:    rgb_d = 8'hE0;
            3'd6:    rgb_d = 8'h03;
            default: rgb_d = 8'h00;
        endcase
        if (!act_d) begin
            rgb_d = 8'h00;
        end
    end

    // Pattern colour registered on the same edge as the pixel outputs
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            vga_rgb <= 8'h00;
        end else if (!en) begin
            vga_rgb <= 8'h00;
        end else if (ce_c) begin
            vga_rgb <= rgb_d;
        end
    end
`else
    assign vga_rgb = 8'h00;
`endif

endmodule
